// File: rtl/beam_threshold_loader.sv
// beam_threshold_loader
// Shadow RAM of per-beam thresholds for two trigger sets. On a load request the
// RAM is streamed, highest beam first, into the beamformer threshold cascade,
// and then the per-set commit strobe is pulsed.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_INIT   | fill both RAM sets with DEFAULT_THRESH, one address per cycle
// ST_IDLE   | accept host writes and load requests
// ST_SHIFT  | read RAM NBEAMS-1..0, present each value with the shift strobe
// ST_COMMIT | last shift on the chain; commit strobe goes out next
// ST_FINISH | commit on the chain; done pulse goes out, writes reopen
module beam_threshold_loader #(
    parameter int                      NBEAMS         = 48,
    parameter int                      THRESH_BITS    = 18,
    parameter logic [THRESH_BITS-1:0]  DEFAULT_THRESH = 18'd4000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic                        wr_set_i,
    input  logic [$clog2(NBEAMS)-1:0]   wr_beam_i,
    input  logic [THRESH_BITS-1:0]      wr_data_i,
    input  logic                        load_i,
    input  logic [1:0]                  load_mask_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    input  logic                        err_clr_i,
    output logic [2*THRESH_BITS-1:0]    thresh_o,
    output logic [1:0]                  thresh_wr_o,
    output logic [1:0]                  thresh_update_o
);

    localparam int              AW       = $clog2(NBEAMS);
    localparam logic [AW-1:0]   LAST     = AW'(NBEAMS - 1);
    localparam logic [AW-1:0]   ADDR_ONE = AW'(1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_FINISH
    } state_t;

    state_t                     state;
    logic [AW-1:0]              addr;
    logic [1:0]                 mask;
    logic [THRESH_BITS-1:0]     ram0 [NBEAMS];
    logic [THRESH_BITS-1:0]     ram1 [NBEAMS];

    logic                       wr_fire;
    logic                       beam_ok;
    logic                       err_set;
    logic [AW-1:0]              init_addr;

    // wr_ready_o is only high in IDLE, so a fired write never races a load read
    assign wr_fire   = wr_valid_i & wr_ready_o & ~rst_i;
    assign beam_ok   = (wr_beam_i <= LAST);
    assign err_set   = (load_i & (state != ST_IDLE)) | (wr_fire & ~beam_ok);
    // INIT reuses the down-counter; addresses are filled 0 upward
    assign init_addr = LAST - addr;

    // Shadow RAM: default fill during INIT, host writes in IDLE
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == ST_INIT) begin
            ram0[init_addr] <= DEFAULT_THRESH;
            ram1[init_addr] <= DEFAULT_THRESH;
        end else if (wr_fire && beam_ok) begin
            if (wr_set_i)
                ram1[wr_beam_i] <= wr_data_i;
            else
                ram0[wr_beam_i] <= wr_data_i;
        end
    end

    // Sequencer FSM with registered chain strobes and status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_INIT;
            addr            <= LAST;
            mask            <= '0;
            thresh_o        <= '0;
            thresh_wr_o     <= '0;
            thresh_update_o <= '0;
            done_o          <= 1'b0;
            busy_o          <= 1'b1;
            wr_ready_o      <= 1'b0;
        end else begin
            done_o          <= 1'b0;
            thresh_update_o <= '0;
            case (state)
                ST_INIT: begin
                    if (addr == '0) begin
                        addr       <= LAST;
                        state      <= ST_IDLE;
                        busy_o     <= 1'b0;
                        wr_ready_o <= 1'b1;
                    end else begin
                        addr <= addr - ADDR_ONE;
                    end
                end
                ST_IDLE: begin
                    if (load_i) begin
                        if (load_mask_i == 2'b00) begin
                            done_o <= 1'b1;
                        end else begin
                            mask       <= load_mask_i;
                            addr       <= LAST;
                            state      <= ST_SHIFT;
                            busy_o     <= 1'b1;
                            wr_ready_o <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    // registered read gives the one-cycle RAM latency
                    thresh_o    <= {ram1[addr], ram0[addr]};
                    thresh_wr_o <= mask;
                    if (addr == '0)
                        state <= ST_COMMIT;
                    else
                        addr <= addr - ADDR_ONE;
                end
                ST_COMMIT: begin
                    thresh_wr_o     <= '0;
                    thresh_update_o <= mask;
                    addr            <= LAST;
                    state           <= ST_FINISH;
                end
                ST_FINISH: begin
                    done_o     <= 1'b1;
                    busy_o     <= 1'b0;
                    wr_ready_o <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                    addr  <= LAST;
                end
            endcase
        end
    end

    // Sticky error flag; a new error event outranks a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_o <= 1'b0;
        else if (err_set)
            err_o <= 1'b1;
        else if (err_clr_i)
            err_o <= 1'b0;
    end

endmodule
